leaf_packet_tx: RTL and testbench

LEAF_PACKET_TX -- requirements
Module: leaf_packet_tx

---
 rtl/leaf_pkg.sv | 39 +++
 rtl/leaf_packet_tx_rr_arbiter.sv | 43 ++++
 rtl/leaf_packet_tx.sv | 146 ++++++++++++++
 tb/tb_leaf_packet_tx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_pkg.sv
// Shared BFT leaf packet layout: field offsets/widths and the packed packet type.
// Build macro LEAF_TX_CREDIT_EN (checked by leaf_packet_tx) enables per-port credit flow control.
package leaf_pkg;

    localparam int PKT_VALID_BIT   = 48;
    localparam int PKT_LEAF_LSB    = 43;
    localparam int PKT_LEAF_W      = 5;
    localparam int PKT_PORT_LSB    = 39;
    localparam int PKT_PORT_W      = 4;
    localparam int PKT_ADDR_LSB    = 32;
    localparam int PKT_ADDR_W      = 7;
    localparam int PKT_PAYLOAD_LSB = 0;
    localparam int PKT_PAYLOAD_W   = 32;
    localparam int PKT_W           = 49;

    typedef struct packed {
        logic                     valid;
        logic [PKT_LEAF_W-1:0]    leaf;
        logic [PKT_PORT_W-1:0]    port;
        logic [PKT_ADDR_W-1:0]    addr;
        logic [PKT_PAYLOAD_W-1:0] payload;
    } leaf_packet_t;

    function automatic leaf_packet_t make_packet(
        input logic [PKT_LEAF_W-1:0]    leaf,
        input logic [PKT_PORT_W-1:0]    port,
        input logic [PKT_ADDR_W-1:0]    addr,
        input logic [PKT_PAYLOAD_W-1:0] payload
    );
        leaf_packet_t pkt;
        pkt.valid   = 1'b1;
        pkt.leaf    = leaf;
        pkt.port    = port;
        pkt.addr    = addr;
        pkt.payload = payload;
        return pkt;
    endfunction

endpackage

// File: rtl/leaf_packet_tx_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, searching from the port after
// the last accepted grant; the pointer only moves when the grant is accepted.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req_i,
    input  logic         accept_i,
    output logic [N-1:0] grant_o
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last_q;
    logic [IW-1:0] last_d;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant_o = '0;
        last_d  = last_q;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(last_q) + i) % N);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                last_d       = idx;
                found        = 1'b1;
            end
        end
    end

    // Resetting to the last port makes port 0 the first one searched.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= IW'(N - 1);
        end else if (accept_i) begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/leaf_packet_tx.sv
// Leaf-to-BFT packet transmitter: arbitrates user streams into one holding register.
// Build macro LEAF_TX_CREDIT_EN enables per-port receiver credits; undefined = unlimited.
module leaf_packet_tx
    import leaf_pkg::*;
#(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_OUT_PORTS         = 2,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
    input  logic                                    cfg_wr,
    input  logic [$clog2(NUM_OUT_PORTS)-1:0]        cfg_port,
    input  logic [NUM_LEAF_BITS-1:0]                cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]                cfg_dest_port,
    input  logic                                    credit_vld,
    input  logic [$clog2(NUM_OUT_PORTS)-1:0]        credit_port,
    input  logic                                    bft_ready,
    output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft,
    input  logic                                    ap_start
);
    localparam int N  = NUM_OUT_PORTS;
    localparam int PW = $clog2(NUM_OUT_PORTS);

    logic [PACKET_BITS-1:0]   pkt_q;
    logic [PACKET_BITS-1:0]   pkt_d;
    logic                     route_vld_q  [N];
    logic [NUM_LEAF_BITS-1:0] route_leaf_q [N];
    logic [NUM_PORT_BITS-1:0] route_port_q [N];
    logic [NUM_ADDR_BITS-1:0] wr_ptr_q     [N];

    logic [N-1:0]  credit_ok;
    logic [N-1:0]  eligible;
    logic [N-1:0]  grant;
    logic [N-1:0]  ack;
    logic          holding_free;
    logic          accept;
    logic [PW-1:0] sel;

    always_comb begin
        holding_free = !pkt_q[PACKET_BITS-1] || bft_ready;
        for (int p = 0; p < N; p++) begin
            eligible[p] = vld_user2interface[p] && route_vld_q[p] && credit_ok[p] && ap_start;
        end
        accept = holding_free && (|eligible) && !reset;
    end

    rr_arbiter #(.N(N)) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    (eligible),
        .accept_i (accept),
        .grant_o  (grant)
    );

    // NOTE: ack is combinational so the user sees the handshake in the same cycle
    // the word is captured; a registered ack would accept one word too many.
    assign ack                = accept ? grant : '0;
    assign ack_interface2user = ack;

    always_comb begin
        sel = '0;
        for (int p = 0; p < N; p++) begin
            if (grant[p]) sel = PW'(p);
        end
    end

    always_comb begin
        pkt_d = pkt_q;
        if (accept) begin
            pkt_d = {1'b1, route_leaf_q[sel], route_port_q[sel], wr_ptr_q[sel],
                     din_leaf_user2interface[sel*PAYLOAD_BITS +: PAYLOAD_BITS]};
        end else if (bft_ready) begin
            pkt_d = '0;
        end
    end

    assign dout_leaf_interface2bft = pkt_q;

    // NOTE: the route table is a handful of flops, so it is reset to "unconfigured"
    // rather than left as an unreset memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_q <= '0;
            for (int p = 0; p < N; p++) begin
                route_vld_q[p]  <= 1'b0;
                route_leaf_q[p] <= '0;
                route_port_q[p] <= '0;
                wr_ptr_q[p]     <= '0;
            end
        end else begin
            pkt_q <= pkt_d;
            if (cfg_wr) begin
                route_vld_q[cfg_port]  <= 1'b1;
                route_leaf_q[cfg_port] <= cfg_dest_leaf;
                route_port_q[cfg_port] <= cfg_dest_port;
            end
            for (int p = 0; p < N; p++) begin
                if (ack[p]) wr_ptr_q[p] <= wr_ptr_q[p] + 1'b1;
            end
        end
    end

`ifdef LEAF_TX_CREDIT_EN
    localparam int CW         = NUM_ADDR_BITS + 1;
    localparam int CREDIT_MAX = 2 ** NUM_ADDR_BITS;

    logic [CW-1:0] credits_q [N];
    logic [CW-1:0] credits_d [N];
    int            credit_sum;

    // Send and return in the same cycle net out before saturating.
    always_comb begin
        credit_sum = 0;
        for (int p = 0; p < N; p++) begin
            credit_sum = int'(credits_q[p]) - int'(ack[p]);
            if (credit_vld && credit_port == PW'(p)) begin
                credit_sum = credit_sum + FREESPACE_UPDATE_SIZE;
            end
            if (credit_sum > CREDIT_MAX) credit_sum = CREDIT_MAX;
            credits_d[p] = CW'(credit_sum);
            credit_ok[p] = (credits_q[p] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < N; p++) credits_q[p] <= CW'(CREDIT_MAX);
        end else begin
            for (int p = 0; p < N; p++) credits_q[p] <= credits_d[p];
        end
    end
`else
    logic unused_credit;
    assign unused_credit = ^{credit_vld, credit_port};
    assign credit_ok     = '1;
`endif

endmodule

// File: tb/tb_leaf_packet_tx.sv
// Scoreboard bench for leaf_packet_tx: a reference model predicts acks and pushes
// expected packets, which are popped and compared as the BFT takes them.
module tb_leaf_packet_tx;
    import leaf_pkg::*;

    localparam int N    = 2;
    localparam int PB   = 32;
    localparam int FS   = 64;
    localparam int CMAX = 128;

    logic            clk;
    logic            reset;
    logic [N*PB-1:0] din;
    logic [N-1:0]    vld;
    logic [N-1:0]    ack;
    logic            cfg_wr;
    logic [0:0]      cfg_port;
    logic [4:0]      cfg_dest_leaf;
    logic [3:0]      cfg_dest_port;
    logic            credit_vld;
    logic [0:0]      credit_port;
    logic            bft_ready;
    logic [48:0]     dout;
    logic            ap_start;

    leaf_packet_tx dut (
        .clk                     (clk),
        .reset                   (reset),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .cfg_wr                  (cfg_wr),
        .cfg_port                (cfg_port),
        .cfg_dest_leaf           (cfg_dest_leaf),
        .cfg_dest_port           (cfg_dest_port),
        .credit_vld              (credit_vld),
        .credit_port             (credit_port),
        .bft_ready               (bft_ready),
        .dout_leaf_interface2bft (dout),
        .ap_start                (ap_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_err;
    int          m_last;
    bit          m_rv   [N];
    logic [4:0]  m_leaf [N];
    logic [3:0]  m_port [N];
    logic [6:0]  m_addr [N];
    int          m_cred [N];
    logic [48:0] sb_q   [$];
    logic [N-1:0] last_ack;
    int          ack_count [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = N - 1;
        for (int p = 0; p < N; p++) begin
            m_rv[p]   = 1'b0;
            m_leaf[p] = '0;
            m_port[p] = '0;
            m_addr[p] = '0;
            m_cred[p] = CMAX;
        end
        sb_q.delete();
    endtask

    // Called at a negedge with inputs already driven; checks, then advances the model.
    task automatic tick();
        logic [N-1:0] elig;
        logic [N-1:0] exp_ack;
        bit           free;
        int           g;
        int           idx;
        leaf_packet_t pkt;
        #1;
        free    = (sb_q.size() == 0) || bft_ready;
        exp_ack = '0;
        g       = -1;
        for (int p = 0; p < N; p++) begin
`ifdef LEAF_TX_CREDIT_EN
            elig[p] = vld[p] && m_rv[p] && ap_start && (m_cred[p] > 0);
`else
            elig[p] = vld[p] && m_rv[p] && ap_start;
`endif
        end
        if (!reset && free) begin
            for (int i = 1; i <= N; i++) begin
                idx = (m_last + i) % N;
                if (g < 0 && elig[idx]) g = idx;
            end
        end
        if (g >= 0) exp_ack[g] = 1'b1;
        check("ack", ack, exp_ack);
        if (sb_q.size() != 0) check("dout", dout, sb_q[0]);
        else                  check("dout_idle", dout, 0);
        last_ack = ack;
        for (int p = 0; p < N; p++) if (ack[p]) ack_count[p]++;

        if (reset) begin
            model_reset();
        end else begin
            if (sb_q.size() != 0 && bft_ready) void'(sb_q.pop_front());
            if (g >= 0) begin
                pkt = make_packet(m_leaf[g], m_port[g], m_addr[g], din[g*PB +: PB]);
                sb_q.push_back(pkt);
                m_addr[g] = m_addr[g] + 7'd1;
                m_last    = g;
`ifdef LEAF_TX_CREDIT_EN
                m_cred[g] = m_cred[g] - 1;
`endif
            end
`ifdef LEAF_TX_CREDIT_EN
            if (credit_vld) begin
                m_cred[credit_port] = m_cred[credit_port] + FS;
                if (m_cred[credit_port] > CMAX) m_cred[credit_port] = CMAX;
            end
`endif
            if (cfg_wr) begin
                m_rv[cfg_port]   = 1'b1;
                m_leaf[cfg_port] = cfg_dest_leaf;
                m_port[cfg_port] = cfg_dest_port;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            din = {$urandom, $urandom};
            tick();
        end
    endtask

    task automatic configure(input logic [0:0] port, input logic [4:0] leaf, input logic [3:0] dport);
        cfg_wr = 1'b1; cfg_port = port; cfg_dest_leaf = leaf; cfg_dest_port = dport;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [8:0] route_f;
    logic [6:0] addr_f;

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b1; din = '0; vld = '0; cfg_wr = 1'b0; cfg_port = '0;
        cfg_dest_leaf = '0; cfg_dest_port = '0; credit_vld = 1'b0; credit_port = '0;
        bft_ready = 1'b1; ap_start = 1'b0;
        for (int p = 0; p < N; p++) ack_count[p] = 0;
        model_reset();
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        check("rst_dout", dout, 0);
        check("rst_ack", ack, 0);

        // Single word with a known route
        ap_start = 1'b1;
        configure(1'b0, 5'd3, 4'd2);
        configure(1'b1, 5'd7, 4'd9);
        vld = 2'b01; din = {32'h0, 32'hDEADBEEF};
        tick();
        vld = 2'b00;
        check("first_pkt", dout, {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF});
        run(2);

        // Both ports requesting: grants alternate (port 0 was granted last)
        vld = 2'b11;
        for (int i = 0; i < 8; i++) begin
            din = {$urandom, $urandom};
            tick();
            check("rr_alt", last_ack, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        vld = 2'b00;
        run(2);

        // Backpressure holds the packet; release drains and acks the next word together
        vld = 2'b01;
        run(1);
        bft_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run(1);
            check("stall_ack", last_ack, 2'b00);
        end
        bft_ready = 1'b1;
        run(1);
        check("drain_ack", last_ack, 2'b01);
        vld = 2'b00;
        run(2);

        // Dropping ap_start stops grants but the held packet still drains
        vld = 2'b01;
        run(1);
        ap_start = 1'b0; bft_ready = 1'b0;
        run(1);
        bft_ready = 1'b1;
        run(1);
        check("nostart_ack", last_ack, 2'b00);
        run(1);
        check("nostart_idle", dout, 0);
        ap_start = 1'b1;

        // Reconfiguring during a send: held packet keeps the old route
        vld = 2'b01;
        cfg_wr = 1'b1; cfg_port = 1'b0; cfg_dest_leaf = 5'd12; cfg_dest_port = 4'd5;
        din = {$urandom, $urandom};
        tick();
        cfg_wr = 1'b0;
        route_f = dout[47:39];
        check("old_route", route_f, {5'd3, 4'd2});
        run(1);
        route_f = dout[47:39];
        check("new_route", route_f, {5'd12, 4'd5});
        vld = 2'b00;
        run(2);

        // Reset with a packet held discards it; route table comes back unconfigured
        vld = 2'b01;
        run(1);
        bft_ready = 1'b0;
        do_reset();
        check("rst_drop", dout, 0);
        bft_ready = 1'b1;
        run(1);
        check("unconfigured", last_ack, 2'b00);
        vld = 2'b00;
        configure(1'b0, 5'd3, 4'd2);

        // Credits after reset: 128 words, then a single return buys 64 more
        for (int p = 0; p < N; p++) ack_count[p] = 0;
        vld = 2'b01;
        run(140);
`ifdef LEAF_TX_CREDIT_EN
        check("credit_stop", ack_count[0], 128);
`else
        check("credit_stop", ack_count[0], 140);
`endif
        ack_count[0] = 0;
        credit_vld = 1'b1; credit_port = 1'b0;
        run(1);
        credit_vld = 1'b0;
        run(80);
`ifdef LEAF_TX_CREDIT_EN
        check("credit_refill", ack_count[0], 64);
`else
        check("credit_refill", ack_count[0], 81);
`endif
        vld = 2'b00;
        run(2);

        // Address wrap over 130 words with continuous credit returns
        do_reset();
        configure(1'b0, 5'd1, 4'd1);
        for (int p = 0; p < N; p++) ack_count[p] = 0;
        vld = 2'b01; credit_vld = 1'b1; credit_port = 1'b0;
        for (int i = 0; i < 300 && ack_count[0] < 130; i++) run(1);
        vld = 2'b00; credit_vld = 1'b0;
        check("wrap_count", ack_count[0], 130);
        addr_f = dout[38:32];
        check("wrap_addr", addr_f, 7'd1);
        run(3);
        check("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
